memoria_param: RTL



---
 rtl/memoria_param.sv | 120 ++++++++++++
 1 files changed

// File: rtl/memoria_param.sv
`default_nettype none
// =============================================================================
// memoria_param : single-port synchronous memory with registered read and a
//                 clear sweep that fills every word with INIT_VAL. Rev 1.0
// =============================================================================
module memoria_param #(
   parameter int                 DATA_W   = 4,
   parameter int                 ADDR_W   = 4,
   parameter int                 DEPTH    = 2**ADDR_W,
   parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              we_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic              clr,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              busy,
   output logic              access_err
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q,      state_d;
   logic [ADDR_W-1:0] ptr_q,        ptr_d;
   logic [DATA_W-1:0] dout_q,       dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              access_err_q, access_err_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              in_range;

   // Extra MSB keeps the compare correct when DEPTH == 2**ADDR_W.
   assign in_range = ({1'b0, addr} < DEPTH_EXT);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      access_err_d = 1'b0;
      mem_we       = 1'b0;
      mem_waddr    = ptr_q;
      mem_wdata    = INIT_VAL;

      case (state_q)
         ST_INIT: begin
            mem_we = 1'b1;
            if (ptr_q == LAST_PTR) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
            access_err_d = ~cs_n;
         end
         default: begin
            if (clr) begin
               // clr takes priority; a coincident access is silently dropped.
               state_d = ST_INIT;
               ptr_d   = '0;
            end else if (!cs_n) begin
               if (!in_range) begin
                  access_err_d = 1'b1;
               end else if (!we_n) begin
                  mem_we    = 1'b1;
                  mem_waddr = addr;
                  mem_wdata = din;
               end else begin
                  dout_d       = mem[addr];
                  dout_valid_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         ptr_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         access_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         access_err_q <= access_err_d;
      end
   end

   // Storage has no reset; the sweep is what establishes known contents.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign access_err = access_err_q;
   assign busy       = (state_q == ST_INIT);

endmodule
`default_nettype wire
